// File: rtl/mips_trace_pkg.sv
// rtl/mips_trace_pkg.sv - commit trace record layout and packing helper
package mips_trace_pkg;

  localparam int KIND_RW = 0;
  localparam int KIND_MR = 1;
  localparam int KIND_MW = 2;

  localparam int TRACE_REC_W = 104;

  localparam int REC_MDATA_LSB  = 0;
  localparam int REC_WBDATA_LSB = 32;
  localparam int REC_REG_LSB    = 64;
  localparam int REC_KIND_LSB   = 69;
  localparam int REC_PC_LSB     = 72;

  function automatic logic [TRACE_REC_W-1:0] pack_rec(
    input logic [31:0] pc,
    input logic [2:0]  kind,
    input logic [4:0]  rd,
    input logic [31:0] wbdata,
    input logic [31:0] mdata
  );
    logic [TRACE_REC_W-1:0] r;
    r = '0;
    r[REC_PC_LSB     +: 32] = pc;
    r[REC_KIND_LSB   +: 3]  = kind;
    r[REC_REG_LSB    +: 5]  = rd;
    r[REC_WBDATA_LSB +: 32] = wbdata;
    r[REC_MDATA_LSB  +: 32] = mdata;
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - generic synchronous FIFO with separate occupancy count
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             pop_fire;
  logic             push_fire;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign rdata = mem[rd_ptr];

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign pop_fire  = pop && !empty;
  assign push_fire = push && (!full || pop_fire);

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_fire) wr_ptr <= wr_ptr + 1'b1;
      if (pop_fire)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_fire, pop_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && !clear && push_fire) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/commit_trace_fifo.sv
// rtl/commit_trace_fifo.sv - packs MEM/WB commit events into records and buffers them
module commit_trace_fifo #(
  parameter int DEPTH  = 16,
  parameter int DROP_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [31:0]              pc,
  input  logic                     wb_reg_write,
  input  logic [4:0]               wb_reg_addr,
  input  logic [31:0]              wb_data,
  input  logic                     mem_read,
  input  logic [31:0]              mem_rdata,
  input  logic                     mem_write,
  input  logic [31:0]              mem_wdata,
  input  logic                     flush,
  output logic                     trace_valid,
  input  logic                     trace_ready,
  output logic [31:0]              trace_pc,
  output logic [2:0]               trace_kind,
  output logic [4:0]               trace_reg,
  output logic [31:0]              trace_wbdata,
  output logic [31:0]              trace_mdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [DROP_W-1:0]        drop_count
);

  import mips_trace_pkg::*;

  logic                   rw_eff;
  logic                   event_seen;
  logic [2:0]             kind;
  logic [31:0]            mdata;
  logic [TRACE_REC_W-1:0] rec;
  logic [TRACE_REC_W-1:0] head;
  logic                   full;
  logic                   empty;
  logic                   drop;

  // Writes to $zero have no architectural effect, so they are not traced.
  assign rw_eff     = wb_reg_write && (wb_reg_addr != 5'd0);
  assign event_seen = rw_eff || mem_read || mem_write;

  always_comb begin
    kind          = 3'b000;
    kind[KIND_RW] = rw_eff;
    kind[KIND_MR] = mem_read;
    kind[KIND_MW] = mem_write;
    if (mem_write)     mdata = mem_wdata;
    else if (mem_read) mdata = mem_rdata;
    else               mdata = 32'h0;
  end

  assign rec = pack_rec(pc, kind,
                        rw_eff ? wb_reg_addr : 5'd0,
                        rw_eff ? wb_data : 32'h0,
                        mdata);

  sync_fifo #(
    .WIDTH (TRACE_REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (flush),
    .push  (event_seen),
    .wdata (rec),
    .pop   (trace_ready),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Full implies non-empty, so a ready consumer always frees a slot this cycle.
  assign drop = event_seen && full && !trace_ready;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_count != '1) drop_count <= drop_count + 1'b1;
    end
  end

  assign trace_valid  = !empty;
  assign trace_pc     = trace_valid ? head[REC_PC_LSB     +: 32] : 32'h0;
  assign trace_kind   = trace_valid ? head[REC_KIND_LSB   +: 3]  : 3'b000;
  assign trace_reg    = trace_valid ? head[REC_REG_LSB    +: 5]  : 5'd0;
  assign trace_wbdata = trace_valid ? head[REC_WBDATA_LSB +: 32] : 32'h0;
  assign trace_mdata  = trace_valid ? head[REC_MDATA_LSB  +: 32] : 32'h0;

endmodule

// File: tb/tb_commit_trace_fifo.sv
// tb/tb_commit_trace_fifo.sv - self-checking bench for commit_trace_fifo
module tb_commit_trace_fifo;

  localparam int DEPTH  = 16;
  localparam int DROP_W = 16;
  localparam int CW     = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [31:0]       pc;
  logic              wb_reg_write;
  logic [4:0]        wb_reg_addr;
  logic [31:0]       wb_data;
  logic              mem_read;
  logic [31:0]       mem_rdata;
  logic              mem_write;
  logic [31:0]       mem_wdata;
  logic              flush;
  logic              trace_valid;
  logic              trace_ready;
  logic [31:0]       trace_pc;
  logic [2:0]        trace_kind;
  logic [4:0]        trace_reg;
  logic [31:0]       trace_wbdata;
  logic [31:0]       trace_mdata;
  logic [CW-1:0]     count;
  logic              overflow;
  logic [DROP_W-1:0] drop_count;

  always #5 clk = ~clk;

  commit_trace_fifo #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc),
    .wb_reg_write(wb_reg_write), .wb_reg_addr(wb_reg_addr), .wb_data(wb_data),
    .mem_read(mem_read), .mem_rdata(mem_rdata),
    .mem_write(mem_write), .mem_wdata(mem_wdata), .flush(flush),
    .trace_valid(trace_valid), .trace_ready(trace_ready),
    .trace_pc(trace_pc), .trace_kind(trace_kind), .trace_reg(trace_reg),
    .trace_wbdata(trace_wbdata), .trace_mdata(trace_mdata),
    .count(count), .overflow(overflow), .drop_count(drop_count)
  );

  typedef struct {
    logic [31:0] pc;
    logic        rw;
    logic [4:0]  addr;
    logic [31:0] wbd;
    logic        mr;
    logic [31:0] rdat;
    logic        mw;
    logic [31:0] wdat;
    logic        exp_push;
    logic [2:0]  exp_kind;
    logic [4:0]  exp_reg;
    logic [31:0] exp_wb;
    logic [31:0] exp_md;
  } vec_t;

  int errors = 0;
  int checks = 0;
  logic [103:0] sb_q[$];
  logic         push_exp;
  logic [103:0] push_rec;
  logic         m_ovf;
  int           m_drop;

  task automatic chk(input string name, input logic [103:0] act, input logic [103:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [103:0] head_now();
    return {trace_pc, trace_kind, trace_reg, trace_wbdata, trace_mdata};
  endfunction

  function automatic logic [103:0] mk(input logic [31:0] p, input logic [2:0] k,
                                      input logic [4:0] r, input logic [31:0] w,
                                      input logic [31:0] m);
    return {p, k, r, w, m};
  endfunction

  task automatic set_event(input logic [31:0] e_pc, input logic e_rw, input logic [4:0] e_addr,
                           input logic [31:0] e_wbd, input logic e_mr, input logic [31:0] e_rd,
                           input logic e_mw, input logic [31:0] e_wd,
                           input logic e_push, input logic [103:0] e_rec);
    pc = e_pc; wb_reg_write = e_rw; wb_reg_addr = e_addr; wb_data = e_wbd;
    mem_read = e_mr; mem_rdata = e_rd; mem_write = e_mw; mem_wdata = e_wd;
    push_exp = e_push; push_rec = e_rec;
  endtask

  task automatic idle();
    set_event(32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, '0);
  endtask

  task automatic push_rw(input logic [31:0] p, input logic [4:0] r, input logic [31:0] w);
    set_event(p, 1'b1, r, w, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, mk(p, 3'b001, r, w, 32'h0));
  endtask

  // One clock: check head on handshake, advance the scoreboard, then check status.
  task automatic cycle();
    bit popping;
    popping = trace_ready && (sb_q.size() > 0);
    chk("valid", {103'h0, trace_valid}, {103'h0, (sb_q.size() > 0)});
    if (popping && trace_valid) chk("head", head_now(), sb_q[0]);
    if (!rst_n || flush) begin
      sb_q.delete();
      m_ovf = 1'b0;
      m_drop = 0;
    end else begin
      if (popping) void'(sb_q.pop_front());
      if (push_exp) begin
        if (sb_q.size() < DEPTH) sb_q.push_back(push_rec);
        else begin
          m_ovf = 1'b1;
          if (m_drop != (2**DROP_W) - 1) m_drop++;
        end
      end
    end
    @(posedge clk);
    #1;
    chk("count", {{(104-CW){1'b0}}, count}, 104'(sb_q.size()));
    chk("overflow", {103'h0, overflow}, {103'h0, m_ovf});
    chk("drop_count", {{(104-DROP_W){1'b0}}, drop_count}, 104'(m_drop));
  endtask

  vec_t tbl[9];

  initial begin
    tbl[0] = '{32'h10, 1, 5'd8,  32'h5,   0, 32'h0,   0, 32'h0,   1, 3'b001, 5'd8,  32'h5,   32'h0};
    tbl[1] = '{32'h14, 1, 5'd0,  32'h7,   0, 32'h0,   0, 32'h0,   0, 3'b000, 5'd0,  32'h0,   32'h0};
    tbl[2] = '{32'h18, 0, 5'd3,  32'h1,   1, 32'h11,  0, 32'h0,   1, 3'b010, 5'd0,  32'h0,   32'h11};
    tbl[3] = '{32'h1c, 1, 5'd3,  32'h9,   0, 32'h0,   1, 32'h2A,  1, 3'b101, 5'd3,  32'h9,   32'h2A};
    tbl[4] = '{32'h20, 0, 5'd0,  32'h0,   1, 32'h55,  1, 32'h66,  1, 3'b110, 5'd0,  32'h0,   32'h66};
    tbl[5] = '{32'h24, 0, 5'd9,  32'hdead,0, 32'hbeef,0, 32'hcafe,0, 3'b000, 5'd0,  32'h0,   32'h0};
    tbl[6] = '{32'h28, 1, 5'd0,  32'h99,  1, 32'h77,  0, 32'h0,   1, 3'b010, 5'd0,  32'h0,   32'h77};
    tbl[7] = '{32'h2c, 1, 5'd31, 32'hCD,  1, 32'hAB,  0, 32'h0,   1, 3'b011, 5'd31, 32'hCD,  32'hAB};
    tbl[8] = '{32'h30, 0, 5'd5,  32'h1,   0, 32'h0,   1, 32'h3,   1, 3'b100, 5'd0,  32'h0,   32'h3};

    m_ovf = 1'b0;
    m_drop = 0;
    rst_n = 1'b0;
    flush = 1'b0;
    trace_ready = 1'b0;
    idle();
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk("reset_valid", {103'h0, trace_valid}, 104'h0);
    chk("reset_count", {{(104-CW){1'b0}}, count}, 104'h0);
    chk("reset_flags", {{(103-DROP_W){1'b0}}, overflow, drop_count}, 104'h0);
    chk("reset_data", head_now(), 104'h0);
    rst_n = 1'b1;

    // Single RW commit, one-cycle push latency, popped next cycle
    trace_ready = 1'b1;
    push_rw(32'h10, 5'd8, 32'h5);
    cycle();
    chk("t1_valid", {103'h0, trace_valid}, {103'h0, 1'b1});
    chk("t1_kind", {101'h0, trace_kind}, {101'h0, 3'b001});
    idle();
    cycle();

    // Write to $zero only: no record
    set_event(32'h14, 1'b1, 5'd0, 32'h42, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, '0);
    cycle();
    idle();
    cycle();

    // Table of event mixes, consumer always ready
    for (int i = 0; i < 9; i++) begin
      set_event(tbl[i].pc, tbl[i].rw, tbl[i].addr, tbl[i].wbd, tbl[i].mr, tbl[i].rdat,
                tbl[i].mw, tbl[i].wdat, tbl[i].exp_push,
                mk(tbl[i].pc, tbl[i].exp_kind, tbl[i].exp_reg, tbl[i].exp_wb, tbl[i].exp_md));
      cycle();
    end
    idle();
    repeat (3) cycle();

    // Backpressure: head holds stable while not ready
    trace_ready = 1'b0;
    set_event(32'h40, 1'b1, 5'd4, 32'h77, 1'b0, 32'h0, 1'b1, 32'h2A, 1'b1,
              mk(32'h40, 3'b101, 5'd4, 32'h77, 32'h2A));
    cycle();
    idle();
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t3_hold", head_now(), mk(32'h40, 3'b101, 5'd4, 32'h77, 32'h2A));
    end
    trace_ready = 1'b1;
    cycle();
    cycle();

    // Overflow: DEPTH+3 pushes with no consumer
    trace_ready = 1'b0;
    for (int i = 0; i < DEPTH + 3; i++) begin
      push_rw(32'h100 + 32'(i * 4), 5'(i % 31 + 1), 32'(i));
      cycle();
    end
    idle();
    chk("t4_count", {{(104-CW){1'b0}}, count}, 104'(DEPTH));
    chk("t4_overflow", {103'h0, overflow}, {103'h0, 1'b1});
    chk("t4_drops", {{(104-DROP_W){1'b0}}, drop_count}, 104'd3);
    trace_ready = 1'b1;
    for (int n = 0; n < 4 * DEPTH && sb_q.size() > 0; n++) cycle();
    chk("t4_drained", 104'(sb_q.size()), 104'h0);

    // Flush clears sticky state; then full + push + pop keeps count at DEPTH
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    trace_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      push_rw(32'h200 + 32'(i * 4), 5'(i + 1), 32'h1000 + 32'(i));
      cycle();
    end
    trace_ready = 1'b1;
    push_rw(32'h2FC, 5'd30, 32'hFEED);
    cycle();
    chk("t5_count", {{(104-CW){1'b0}}, count}, 104'(DEPTH));
    chk("t5_overflow", {103'h0, overflow}, 104'h0);
    idle();
    for (int n = 0; n < 4 * DEPTH && sb_q.size() > 0; n++) cycle();
    chk("t5_drained", 104'(sb_q.size()), 104'h0);

    // Half-full after an overflow, then flush racing a push and pop
    trace_ready = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      push_rw(32'h300 + 32'(i * 4), 5'd7, 32'(i));
      cycle();
    end
    idle();
    trace_ready = 1'b1;
    for (int i = 0; i < DEPTH / 2; i++) cycle();
    flush = 1'b1;
    push_rw(32'h3FC, 5'd9, 32'h5A5A);
    cycle();
    flush = 1'b0;
    idle();
    chk("t6_valid", {103'h0, trace_valid}, 104'h0);
    chk("t6_count", {{(104-CW){1'b0}}, count}, 104'h0);
    chk("t6_flags", {{(103-DROP_W){1'b0}}, overflow, drop_count}, 104'h0);
    repeat (2) cycle();

    // Reset mid-stream discards buffered records
    trace_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push_rw(32'h400 + 32'(i * 4), 5'd2, 32'(i));
      cycle();
    end
    idle();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    chk("rst_mid_count", {{(104-CW){1'b0}}, count}, 104'h0);
    trace_ready = 1'b1;
    repeat (2) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
